// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock line, issues a request-to-send,
// shifts out data/parity/stop on device clock falling edges and checks the device ACK.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       kbclk_in,
  input  logic       kbdata_in,
  output logic       kbclk_oe,
  output logic       kbdata_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE
  } state_t;

  state_t           state, state_n;
  logic             clk_s1, clk_s2, clk_prev;
  logic             dat_s1, dat_s2;
  logic             fall;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [3:0]       bit_cnt;
  logic [7:0]       data_q;
  logic             parity_q;
  logic             drive_q;
  logic             load;
  logic             timed;
  logic             timeout;
  logic             done_n, err_n;

  assign fall    = clk_prev & ~clk_s2;
  assign timed   = (state == REQ) || (state == SEND) || (state == ACK) || (state == WAIT_IDLE);
  assign timeout = timed && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_n = state;
    load    = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE:      if (tx_valid) begin
                   load    = 1'b1;
                   state_n = INHIBIT;
                 end
      INHIBIT:   if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) state_n = REQ;
      REQ:       state_n = SEND;
      SEND:      if (fall && bit_cnt == 4'd9) state_n = ACK;
      ACK:       if (fall) begin
                   if (dat_s2) begin
                     err_n   = 1'b1;
                     state_n = IDLE;
                   end else begin
                     state_n = WAIT_IDLE;
                   end
                 end
      WAIT_IDLE: if (clk_s2 && dat_s2) begin
                   done_n  = 1'b1;
                   state_n = IDLE;
                 end
      default:   state_n = IDLE;
    endcase
    // Timeout overrides any other outcome, which also keeps done and err exclusive.
    if (timeout) begin
      state_n = IDLE;
      done_n  = 1'b0;
      err_n   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      inh_cnt  <= '0;
      to_cnt   <= '0;
      bit_cnt  <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      drive_q  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      clk_s1   <= kbclk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= kbdata_in;
      dat_s2   <= dat_s1;
      // Pulses are registered so they coincide with the first IDLE cycle.
      done     <= done_n;
      err      <= err_n;

      inh_cnt <= (state == INHIBIT) ? inh_cnt + INH_W'(1) : '0;
      to_cnt  <= timed ? to_cnt + TO_W'(1) : '0;

      if (load) begin
        data_q   <= tx_data;
        parity_q <= ~^tx_data;
        bit_cnt  <= '0;
      end

      if (state == REQ) drive_q <= 1'b1;

      if (state == SEND && fall) begin
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt < 4'd8)       drive_q <= ~data_q[bit_cnt[2:0]];
        else if (bit_cnt == 4'd8) drive_q <= ~parity_q;
        else                      drive_q <= 1'b0;
      end

      if (state == ACK && fall) bit_cnt <= 4'd11;
    end
  end

  assign tx_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign kbclk_oe  = (state == INHIBIT);
  assign kbdata_oe = (state == REQ) || ((state == SEND) && drive_q);

endmodule

// File: tb/tb_ps2_tx.sv
// Self-checking bench for ps2_tx: the bench plays the PS/2 device and compares the
// host's line drive against a frame model built from the PS/2 framing rules.
module tb_ps2_tx;

  localparam int INH = 10;
  localparam int TO  = 200;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       kbclk_oe, kbdata_oe;
  logic       busy, done, err;
  logic       dev_clk, dev_data;
  logic       kbclk_in, kbdata_in;

  int total = 0;
  int bad   = 0;
  int done_seen = 0;
  int err_seen  = 0;
  int both_seen = 0;

  // Open-drain wired-AND of host and device on each line.
  assign kbclk_in  = dev_clk  & ~kbclk_oe;
  assign kbdata_in = dev_data & ~kbdata_oe;

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .kbclk_in  (kbclk_in),
    .kbdata_in (kbdata_in),
    .kbclk_oe  (kbclk_oe),
    .kbdata_oe (kbdata_oe),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_seen <= done_seen + 1;
    if (err === 1'b1)  err_seen  <= err_seen + 1;
    if (done === 1'b1 && err === 1'b1) both_seen <= both_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Host line drive per frame slot: start 0, data LSB first, odd parity, stop 1; oe = ~bit.
  function automatic logic [10:0] expected_oe(input logic [7:0] d);
    logic [10:0] frame;
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame[i+1] = d[i];
    frame[9]  = ($countones(d) % 2 == 0);
    frame[10] = 1'b1;
    return ~frame;
  endfunction

  task automatic start_req(input logic [7:0] d, input bit poke);
    int cnt;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    cnt = 0;
    while (kbclk_oe === 1'b1 && cnt < 1000) begin
      cnt++;
      if (poke && cnt == 3) begin
        tx_valid = 1'b1;
        tx_data  = ~d;
      end else begin
        tx_valid = 1'b0;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("inhibit_len", cnt, INH);
    check("req_data_oe", kbdata_oe, 1'b1);
    check("req_clk_oe", kbclk_oe, 1'b0);
  endtask

  task automatic dev_edges(input int n_edges, input logic ack, output logic [10:0] seen);
    seen = '0;
    for (int n = 1; n <= n_edges; n++) begin
      repeat (5) @(negedge clk);
      seen[n-1] = kbdata_oe;
      if (n == 11) begin
        dev_data = ack;
        repeat (2) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (5) @(negedge clk);
      dev_clk = 1'b1;
      if (n == 11) dev_data = 1'b1;
    end
  endtask

  task automatic full_xfer(input logic [7:0] d, input logic ack, input bit poke);
    logic [10:0] seen;
    int d0, e0;
    d0 = done_seen;
    e0 = err_seen;
    start_req(d, poke);
    dev_edges(11, ack, seen);
    repeat (20) @(negedge clk);
    check($sformatf("frame_%02h", d), seen, expected_oe(d));
    check("done_count", done_seen - d0, ack ? 0 : 1);
    check("err_count", err_seen - e0, ack ? 1 : 0);
    check("ready_after", tx_ready, 1'b1);
    check("busy_after", busy, 1'b0);
  endtask

  initial begin
    logic [10:0] partial;
    int k, d0, e0;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_clk_oe", kbclk_oe, 1'b0);
    check("rst_data_oe", kbdata_oe, 1'b0);
    check("rst_done_err", {done, err}, 2'b00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    full_xfer(8'hED, 1'b0, 1'b0);
    full_xfer(8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) full_xfer(8'($urandom), 1'b0, (i == 1));

    // Device never acknowledges.
    full_xfer(8'($urandom), 1'b1, 1'b0);

    // No device clock at all.
    e0 = err_seen;
    start_req(8'h5A, 1'b0);
    k = 0;
    while (err !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", k, TO);
    check("timeout_oe", {kbclk_oe, kbdata_oe}, 2'b00);
    repeat (5) @(negedge clk);
    check("timeout_err_once", err_seen - e0, 1);

    // Reset part-way through a frame.
    start_req(8'h3C, 1'b0);
    dev_edges(5, 1'b0, partial);
    check("partial_frame", partial[4:0], expected_oe(8'h3C) & 11'h01F);
    #2 rst_n = 1'b0;
    #1;
    check("abort_oe", {kbclk_oe, kbdata_oe}, 2'b00);
    check("abort_ready", tx_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_seen;
    e0 = err_seen;
    repeat (300) @(negedge clk);
    check("abort_no_pulse", {16'(done_seen - d0), 16'(err_seen - e0)}, 32'h0);
    full_xfer(8'hF4, 1'b0, 1'b0);

    check("done_err_exclusive", both_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, meaning clk cycles the clock line is held low before a request (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, meaning the clk-cycle limit from request start to ACK completion.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port tx_data  input  8  command byte to send to the device.
REQ-006 SHALL have port tx_valid  input  1  request to send tx_data.
REQ-007 SHALL have port tx_ready  output  1  high when IDLE and able to accept a byte.
REQ-008 SHALL have port kbclk_in  input  1  raw PS/2 clock line level (asynchronous).
REQ-009 SHALL have port kbdata_in  input  1  raw PS/2 data line level (asynchronous).
REQ-010 SHALL have port kbclk_oe  output  1  1 = pull the PS/2 clock line low (open-drain).
REQ-011 SHALL have port kbdata_oe  output  1  1 = pull the PS/2 data line low (open-drain).
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-clk pulse on successful, acknowledged transfer.
REQ-014 SHALL have port err  output  1  one-clk pulse on missing ACK or timeout.

Function
REQ-015 SHALL synchronize kbclk_in and kbdata_in through 2-FF synchronizers; the falling-edge event is sync-clock prev=1, cur=0.
REQ-016 SHALL implement FSM states IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
REQ-017 IDLE: tx_ready=1, both oe=0; tx_valid=1 latches tx_data, computes odd parity (parity = ~^tx_data), clears the bit counter, and enters INHIBIT on the next edge.
REQ-018 INHIBIT: kbclk_oe=1, kbdata_oe=0 for exactly INHIBIT_CYCLES clk cycles, then REQ.
REQ-019 REQ: kbdata_oe=1 (start bit 0), kbclk_oe=0; the timeout counter starts at REQ entry; enter SEND on the next clk.
REQ-020 SEND: on each falling edge n=1..8, drive data bit n-1 (LSB first); on n=9, drive parity; on n=10, drive stop (kbdata_oe=0); then enter ACK.
REQ-021 SEND drive rule: kbdata_oe = ~bit value; the value SHALL be held until the next falling edge.
REQ-022 ACK: on the 11th falling edge, sample the synchronized data; 0 enters WAIT_IDLE, 1 pulses err and returns to IDLE.
REQ-023 WAIT_IDLE: wait until both synchronized lines are high, then pulse done for 1 clk and return to IDLE.
REQ-024 Timeout: if the counter reaches TIMEOUT_CYCLES in REQ/SEND/ACK/WAIT_IDLE, SHALL release both lines, pulse err, and enter IDLE in the same clk.
REQ-025 tx_valid while busy SHALL be ignored, with no effect on the latched byte.
REQ-026 done and err SHALL never be high in the same cycle.
REQ-027 Counters SHALL be sized ceil(log2(param+1)) bits; the bit counter is 4 bits, 0..11, and SHALL not wrap.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE and kbclk_oe=0, kbdata_oe=0, busy=0, done=0, err=0, tx_ready=1, and clear all counters and synchronizers (sync regs to 1).
REQ-029 Reset mid-transfer SHALL release both lines immediately and discard the byte; after reset, no done/err pulse is produced for the aborted byte.

Verification
REQ-030 tx_data=0xED, device model clocks 11 edges and ACKs -> kbdata_oe sequence start 1, bits 0,1,0,0,1,0,0,0, parity 0, stop 0; done pulse once.
REQ-031 tx_data=0x02 -> parity bit 0 on the line (kbdata_oe=1 on edge 9); done pulse.
REQ-032 INHIBIT_CYCLES=10 -> kbclk_oe high exactly 10 clk cycles after the accept edge, then kbdata_oe=1.
REQ-033 Device leaves data high at the 11th edge -> err pulse, no done, IDLE, tx_ready=1.
REQ-034 No device clock, TIMEOUT_CYCLES=200 -> err pulse 200 clk cycles after REQ entry; both oe=0.
REQ-035 rst_n asserted after edge 5, then tx_valid with 0xF4 -> clean full transfer, done pulse, no stray err.
